line_fb_vga: RTL and testbench

Downstream consumer of the line stepper's (x,y) position stream. Each accepted 4-bit (x,y) coordinate is plotted into a 16x16 one-bit framebuffer. The framebuffer is scanned out continuously as 640x480 VGA with 12-bit RGB and hs/vs. Each grid cell is shown as a 16x16-pixel block, and the 256x256 grid is centred on screen.

---
 rtl/line_fb_vga.sv | 174 +++++++++++++++++
 tb/tb_line_fb_vga.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_fb_vga.sv
// 16x16 one-bit framebuffer fed by a plot stream, scanned out as 640x480 VGA (16x16-pixel cells, centred).
// Define GRID_LINES_EN to draw dim grey cell boundaries over empty cells.
`timescale 1ns/1ps
module line_fb_vga #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int X_OFF    = 192,
  parameter int Y_OFF    = 112
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_valid,
  input  logic [3:0] pix_x,
  input  logic [3:0] pix_y,
  output logic       pix_ready,
  input  logic       clear_req,
  output logic       clear_busy,
  output logic [3:0] r,
  output logic [3:0] g,
  output logic [3:0] b,
  output logic       hs,
  output logic       vs,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_clr_addr;
  logic [7:0] w_clr_addr_nxt;
  logic       w_fb_we;
  logic       w_fb_wdat;
  logic [7:0] w_fb_addr;
  logic [255:0] r_fb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_clr_addr <= w_clr_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_clr_addr_nxt = r_clr_addr;
    w_fb_we        = 1'b0;
    w_fb_wdat      = 1'b0;
    w_fb_addr      = r_clr_addr;
    pix_ready      = 1'b0;
    clear_busy     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        clear_busy     = 1'b1;
        w_fb_we        = 1'b1;
        w_clr_addr_nxt = r_clr_addr + 8'd1;
        if (r_clr_addr == 8'hFF) w_state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        // A clear request blocks the plot in the same cycle so it cannot race the wipe.
        pix_ready = !clear_req;
        if (clear_req) begin
          w_state_nxt    = ST_CLEAR;
          w_clr_addr_nxt = '0;
        end else if (pix_valid) begin
          w_fb_we   = 1'b1;
          w_fb_wdat = 1'b1;
          w_fb_addr = {pix_y, pix_x};
        end
      end
      default: w_state_nxt = ST_CLEAR;
    endcase
  end

  // No reset here: the power-up clear initialises the array.
  always_ff @(posedge clk) begin
    if (w_fb_we) r_fb[w_fb_addr] <= w_fb_wdat;
  end

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == 10'(H_TOTAL - 1)) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : r_v_cnt + 10'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 10'd1;
    end
  end

  logic       w_active;
  logic       w_in_grid;
  logic [7:0] w_hx;
  logic [7:0] w_vy;
  logic [7:0] w_cell;
  logic       w_bit;
  logic [11:0] w_rgb;
  logic       w_hs;
  logic       w_vs;
  logic       w_fs;

  assign w_active  = (r_h_cnt < 10'(H_ACTIVE)) && (r_v_cnt < 10'(V_ACTIVE));
  assign w_in_grid = w_active
                     && (r_h_cnt >= 10'(X_OFF)) && (r_h_cnt < 10'(X_OFF + 256))
                     && (r_v_cnt >= 10'(Y_OFF)) && (r_v_cnt < 10'(Y_OFF + 256));
  assign w_hx      = 8'(r_h_cnt - 10'(X_OFF));
  assign w_vy      = 8'(r_v_cnt - 10'(Y_OFF));
  assign w_cell    = {w_vy[7:4], w_hx[7:4]};
  assign w_bit     = r_fb[w_cell];

  always_comb begin
    w_rgb = 12'h000;
    if (w_in_grid) begin
      if (w_bit) begin
        w_rgb = 12'hFFF;
      end else begin
`ifdef GRID_LINES_EN
        w_rgb = ((w_hx[3:0] == 4'd0) || (w_vy[3:0] == 4'd0)) ? 12'h333 : 12'h000;
`else
        w_rgb = 12'h000;
`endif
      end
    end else if (w_active) begin
      w_rgb = 12'h004;
    end
  end

  assign w_hs = !((r_h_cnt >= 10'(H_ACTIVE + H_FP)) && (r_h_cnt < 10'(H_ACTIVE + H_FP + H_SYNC)));
  assign w_vs = !((r_v_cnt >= 10'(V_ACTIVE + V_FP)) && (r_v_cnt < 10'(V_ACTIVE + V_FP + V_SYNC)));
  assign w_fs = (r_h_cnt == 10'd0) && (r_v_cnt == 10'd0);

  logic [11:0] r_rgb;
  logic        r_hs;
  logic        r_vs;
  logic        r_fs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb <= 12'h000;
      r_hs  <= 1'b1;
      r_vs  <= 1'b1;
      r_fs  <= 1'b0;
    end else begin
      r_rgb <= w_rgb;
      r_hs  <= w_hs;
      r_vs  <= w_vs;
      r_fs  <= w_fs;
    end
  end

  assign r           = r_rgb[11:8];
  assign g           = r_rgb[7:4];
  assign b           = r_rgb[3:0];
  assign hs          = r_hs;
  assign vs          = r_vs;
  assign frame_start = r_fs;

endmodule

// File: tb/tb_line_fb_vga.sv
// Scoreboard bench: a compact-geometry instance exercises plotting/clear over a full frame,
// and a default-geometry instance checks the 640x480 sync/border timing on the first lines.
`timescale 1ns/1ps
module tb_line_fb_vga;

  localparam int S_HA = 264, S_HFP = 2, S_HS = 4, S_HBP = 2;
  localparam int S_VA = 260, S_VFP = 2, S_VS = 2, S_VBP = 2;
  localparam int S_XO = 4, S_YO = 2;
  localparam int S_HT = 272, S_VT = 266;

  localparam int D_HA = 640, D_HFP = 16, D_HS = 96;
  localparam int D_VA = 480, D_VFP = 10, D_VS = 2;
  localparam int D_XO = 192, D_YO = 112;
  localparam int D_HT = 800, D_VT = 525;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_valid;
  logic [3:0] pix_x;
  logic [3:0] pix_y;
  logic       clear_req;

  logic       s_rdy, s_busy, s_hs, s_vs, s_fs;
  logic [3:0] s_r, s_g, s_b;
  logic       d_rdy, d_busy, d_hs, d_vs, d_fs;
  logic [3:0] d_r, d_g, d_b;

  always #5 clk = ~clk;

  line_fb_vga #(
    .H_ACTIVE(S_HA), .H_FP(S_HFP), .H_SYNC(S_HS), .H_BP(S_HBP),
    .V_ACTIVE(S_VA), .V_FP(S_VFP), .V_SYNC(S_VS), .V_BP(S_VBP),
    .X_OFF(S_XO), .Y_OFF(S_YO)
  ) u_small (
    .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
    .pix_ready(s_rdy), .clear_req(clear_req), .clear_busy(s_busy),
    .r(s_r), .g(s_g), .b(s_b), .hs(s_hs), .vs(s_vs), .frame_start(s_fs)
  );

  line_fb_vga u_dflt (
    .clk(clk), .rst(rst), .pix_valid(1'b0), .pix_x(4'd0), .pix_y(4'd0),
    .pix_ready(d_rdy), .clear_req(1'b0), .clear_busy(d_busy),
    .r(d_r), .g(d_g), .b(d_b), .hs(d_hs), .vs(d_vs), .frame_start(d_fs)
  );

  typedef struct {
    int          col;
    int          row;
    logic [11:0] rgb;
  } item_t;

  item_t sb_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 30) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] empty_rgb(input int lc, input int lr);
`ifdef GRID_LINES_EN
    return (((lc % 16) == 0) || ((lr % 16) == 0)) ? 12'h333 : 12'h000;
`else
    return 12'h000;
`endif
  endfunction

  function automatic void push(input int c, input int rr, input logic [11:0] v);
    item_t it;
    it.col = c;
    it.row = rr;
    it.rgb = v;
    sb_q.push_back(it);
  endfunction

  // Monitor for the compact instance: tracks raster position from frame_start.
  int s_col = 0, s_row = 0, s_frames = 0;
  bit s_sync = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!s_sync) begin
          if (s_fs) begin
            s_sync = 1; s_col = 0; s_row = 0; s_frames = 1;
          end
        end else begin
          s_col++;
          if (s_col == S_HT) begin
            s_col = 0;
            s_row++;
            if (s_row == S_VT) s_row = 0;
          end
          chk("s_frame_start", 32'(s_fs), 32'((s_col == 0) && (s_row == 0)));
          if (s_fs) s_frames++;
        end
        if (s_sync) begin
          bit act, grid;
          act  = (s_col < S_HA) && (s_row < S_VA);
          grid = act && (s_col >= S_XO) && (s_col < S_XO + 256) && (s_row >= S_YO) && (s_row < S_YO + 256);
          chk("s_hs", 32'(s_hs), 32'(!((s_col >= S_HA + S_HFP) && (s_col < S_HA + S_HFP + S_HS))));
          chk("s_vs", 32'(s_vs), 32'(!((s_row >= S_VA + S_VFP) && (s_row < S_VA + S_VFP + S_VS))));
          if (!grid) chk("s_bg_rgb", 32'({s_r, s_g, s_b}), act ? 32'h004 : 32'h000);
          if (sb_q.size() > 0 && sb_q[0].col == s_col && sb_q[0].row == s_row) begin
            item_t it;
            it = sb_q.pop_front();
            chk($sformatf("pix(%0d,%0d)", it.col, it.row), 32'({s_r, s_g, s_b}), 32'(it.rgb));
          end
        end
      end
    end
  end

  // Monitor for the default-geometry instance (only the lines above the grid are reached).
  int d_col = 0, d_row = 0;
  bit d_sync = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!d_sync) begin
          if (d_fs) begin
            d_sync = 1; d_col = 0; d_row = 0;
          end
        end else begin
          d_col++;
          if (d_col == D_HT) begin
            d_col = 0;
            d_row++;
            if (d_row == D_VT) d_row = 0;
          end
          chk("d_frame_start", 32'(d_fs), 32'((d_col == 0) && (d_row == 0)));
        end
        if (d_sync) begin
          bit act, grid;
          act  = (d_col < D_HA) && (d_row < D_VA);
          grid = act && (d_col >= D_XO) && (d_col < D_XO + 256) && (d_row >= D_YO) && (d_row < D_YO + 256);
          chk("d_hs", 32'(d_hs), 32'(!((d_col >= D_HA + D_HFP) && (d_col < D_HA + D_HFP + D_HS))));
          chk("d_vs", 32'(d_vs), 32'(!((d_row >= D_VA + D_VFP) && (d_row < D_VA + D_VFP + D_VS))));
          if (!grid) chk("d_bg_rgb", 32'({d_r, d_g, d_b}), act ? 32'h004 : 32'h000);
        end
      end
    end
  end

  task automatic count_clear(output int n, output bit rdy_seen);
    n = 0;
    rdy_seen = 0;
    #1;
    while (s_busy && n < 1000) begin
      if (s_rdy) rdy_seen = 1;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic plot(input int x, input int y);
    pix_x = 4'(x);
    pix_y = 4'(y);
    pix_valid = 1'b1;
    #1;
    chk($sformatf("plot_rdy(%0d,%0d)", x, y), 32'(s_rdy), 32'd1);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k;
    k = 0;
    while (sb_q.size() > 0 && k < 80000) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    int  n;
    bit  rdy_seen;
    int  k;
    rst = 1'b1;
    pix_valid = 1'b0;
    pix_x = 4'd0;
    pix_y = 4'd0;
    clear_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_hs", 32'(s_hs), 32'd1);
    chk("rst_vs", 32'(s_vs), 32'd1);
    chk("rst_rgb", 32'({s_r, s_g, s_b}), 32'h000);
    chk("rst_fs", 32'(s_fs), 32'd0);
    chk("rst_busy", 32'(s_busy), 32'd1);
    chk("rst_rdy", 32'(s_rdy), 32'd0);
    chk("rst_d_hs", 32'(d_hs), 32'd1);
    rst = 1'b0;

    count_clear(n, rdy_seen);
    chk("init_clear_len", 32'(n), 32'd256);
    chk("init_clear_rdy", 32'(rdy_seen), 32'd0);
    chk("idle_busy", 32'(s_busy), 32'd0);
    chk("idle_rdy", 32'(s_rdy), 32'd1);

    plot(0, 0);
    plot(7, 14);
    // Cell (0,0) occupies columns 4..19 on lines 2..17 of the compact raster.
    for (int ln = S_YO; ln < S_YO + 16; ln++) begin
      if (ln == S_YO) push(S_XO - 1, ln, 12'h004);
      for (int c = S_XO; c < S_XO + 16; c++) push(c, ln, 12'hFFF);
      if (ln == S_YO) push(S_XO + 16, ln, empty_rgb(16, 0));
    end
    push(S_XO, S_YO + 16, empty_rgb(0, 16));
    wait_drain("drain_row0");

    clear_req = 1'b1;
    pix_valid = 1'b1;
    pix_x = 4'd5;
    pix_y = 4'd14;
    #1;
    chk("clr_req_rdy", 32'(s_rdy), 32'd0);
    chk("clr_req_busy", 32'(s_busy), 32'd0);
    @(negedge clk);
    clear_req = 1'b0;
    pix_valid = 1'b0;
    count_clear(n, rdy_seen);
    chk("clear_len", 32'(n), 32'd256);
    chk("clear_rdy", 32'(rdy_seen), 32'd0);

    plot(15, 15);
    push(S_XO + 80, S_YO + 224, empty_rgb(80, 224));
    push(S_XO + 112, S_YO + 224, empty_rgb(112, 224));
    push(S_XO + 113, S_YO + 225, empty_rgb(113, 225));
    for (int ln = S_YO + 240; ln < S_YO + 256; ln++) begin
      if (ln == S_YO + 240) push(S_XO + 239, ln, empty_rgb(239, 240));
      for (int c = S_XO + 240; c < S_XO + 256; c++) push(c, ln, 12'hFFF);
      if (ln == S_YO + 240) push(S_XO + 256, ln, 12'h004);
    end
    push(S_XO + 255, S_YO + 256, 12'h004);
    wait_drain("drain_row15");

    k = 0;
    while (s_frames < 2 && k < 80000) begin
      @(negedge clk);
      k++;
    end
    chk("frame_count", 32'(s_frames), 32'd2);
    chk("d_synced", 32'(d_sync), 32'd1);
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
